// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int NUM_PORTS  = 2;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_STRB_W = DEF_DATA_W / 8;

    // Byte-enable width for a given word width.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_strb_merge.sv
// Combinational byte merge: each byte comes from new_word where its strobe is
// set, otherwise from old_word. Shared with future cache fill logic.
module dmem_strb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);

    // Per-byte select between the new and the old word.
    always_comb begin
        merged = old_word;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Port 0 = core load/store unit, port 1 = DMA / program loader.
// Writes are merged with the current word in the same cycle (read-merge-write),
// responses are registered one cycle after the grant, and a lock keeps one
// port as exclusive owner for read-modify-write sequences.
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; without it
// port 0 always wins a tie and the last-grant register is not built.
//
// state | meaning
// IDLE  | arbitrate between both ports
// LOCK0 | port 0 owns memory exclusively
// LOCK1 | port 1 owns memory exclusively
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                req_valid,
    output logic [NUM_PORTS-1:0]                req_ready,
    input  logic [NUM_PORTS-1:0]                req_we,
    input  logic [NUM_PORTS-1:0]                req_lock,
    input  logic [NUM_PORTS-1:0][31:0]          req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    req_wdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]  req_wstrb,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]    rsp_rdata,
    output logic                                mem_we,
    output logic [31:0]                         mem_addr,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic [DATA_W-1:0]                   mem_rdata
);

    // The memory only decodes the low ADDR_W bits; the full address is passed
    // through untouched, so the width only needs to fit in the address bus.
    if (ADDR_W < 1 || ADDR_W > 32) begin : g_bad_addr_w
        $error("dmem_arbiter: ADDR_W must be in 1..32");
    end

    arb_state_t             state, state_nxt;
    logic [NUM_PORTS-1:0]   gnt;
    logic                   gnt_any;
    logic                   sel;
    logic                   tie_pick1;

`ifdef DMEM_ARB_RR_EN
    logic                   last;

    // Last granted port; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (gnt_any) begin
            last <= sel;
        end
    end

    assign tie_pick1 = ~last;
`else
    assign tie_pick1 = 1'b0;
`endif

    // Grant decode and next state; nothing is granted while reset is held.
    always_comb begin
        gnt       = '0;
        state_nxt = state;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (req_valid == 2'b11) begin
                        gnt = tie_pick1 ? 2'b10 : 2'b01;
                    end else begin
                        gnt = req_valid;
                    end
                end
                LOCK0:   gnt = {1'b0, req_valid[0]};
                LOCK1:   gnt = {req_valid[1], 1'b0};
                default: gnt = '0;
            endcase
        end
        gnt_any = |gnt;
        sel     = gnt[1];
        if (gnt_any) begin
            if (req_lock[sel]) begin
                state_nxt = sel ? LOCK1 : LOCK0;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    assign req_ready = gnt;

    // Memory drive from the winning port; address parks at 0 when idle.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        if (gnt_any) begin
            mem_addr = req_addr[sel];
            mem_we   = req_we[sel];
        end
    end

    dmem_strb_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_word (mem_rdata),
        .new_word (req_wdata[sel]),
        .strb     (req_wstrb[sel]),
        .merged   (mem_wdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered responses; read data holds between responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= gnt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt[p]) begin
                    rsp_rdata[p] <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req_valid, req_ready, req_we, req_lock, rsp_valid;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0][3:0]  req_wstrb;
    logic             mem_we;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [31:0]      mem [0:255];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Response scoreboard: every response pops the oldest expectation of its port.
    always @(negedge clk) begin : rsp_mon
        logic [31:0] e;
        if (rsp_valid[0] === 1'b1) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL rsp0_unexpected: got %h with no response pending", rsp_rdata[0]);
            end else begin
                e = exp_q0.pop_front();
                if (rsp_rdata[0] !== e) begin
                    errors++;
                    $display("FAIL rsp0_rdata: got %h want %h", rsp_rdata[0], e);
                end
            end
        end
        if (rsp_valid[1] === 1'b1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL rsp1_unexpected: got %h with no response pending", rsp_rdata[1]);
            end else begin
                e = exp_q1.pop_front();
                if (rsp_rdata[1] !== e) begin
                    errors++;
                    $display("FAIL rsp1_rdata: got %h want %h", rsp_rdata[1], e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_lock[p]  = lock;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_wstrb[p] = strb;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr();
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_wstrb = '1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        tick();
        reset = 1'b1;
        clr();
        @(negedge clk);
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr: got %h want 0", mem_addr); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b want 00", req_ready); end
        tick();
    endtask

    task automatic test_single_read();
        mem[8'h10] = 32'hDEAD_BEEF;
        clr();
        set_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL read_ready: got %b want 01", req_ready); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h want 10", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL read_we: got %b want 0", mem_we); end
        exp_q0.push_back(32'hDEAD_BEEF);
        tick();
        clr();
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL read_rsp_one_cycle: got %b want 00", rsp_valid); end
        checks++; if (rsp_rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata_hold: got %h want deadbeef", rsp_rdata[0]); end
        tick();
    endtask

    task automatic test_strobed_write();
        mem[8'h04] = 32'h1122_3344;
        clr();
        set_req(1, 1'b1, 1'b0, 32'h4, 32'hAABB_CCDD, 4'b0101);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_ready: got %b want 10", req_ready); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", mem_we); end
        checks++; if (mem_wdata !== 32'h11BB_33DD) begin errors++; $display("FAIL wr_merge: got %h want 11bb33dd", mem_wdata); end
        exp_q1.push_back(32'h1122_3344);
        tick();
        clr();
        set_req(0, 1'b1, 1'b0, 32'h4, 32'hFFFF_FFFF, 4'b0000);
        @(negedge clk);
        checks++; if (mem[8'h04] !== 32'h11BB_33DD) begin errors++; $display("FAIL wr_mem_word: got %h want 11bb33dd", mem[8'h04]); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr0_ready: got %b want 01", req_ready); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr0_we: got %b want 1", mem_we); end
        checks++; if (mem_wdata !== 32'h11BB_33DD) begin errors++; $display("FAIL wr0_unchanged: got %h want 11bb33dd", mem_wdata); end
        exp_q0.push_back(32'h11BB_33DD);
        tick();
        clr();
        @(negedge clk);
        tick();
    endtask

    task automatic test_tie();
        logic [1:0] exp;
        reset = 1'b0;
        clr();
        tick();
        reset = 1'b1;
        mem[8'h30] = 32'hA0A0_A0A0;
        mem[8'h31] = 32'hB1B1_B1B1;
        set_req(0, 1'b0, 1'b0, 32'h30, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h31, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            exp = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL tie_grant[%0d]: got %b want %b", i, req_ready, exp); end
            if (exp == 2'b01) exp_q0.push_back(32'hA0A0_A0A0);
            else              exp_q1.push_back(32'hB1B1_B1B1);
            tick();
        end
        clr();
        @(negedge clk);
        tick();
    endtask

    task automatic test_lock();
        mem[8'h08] = 32'h0000_0888;
        clr();
        set_req(1, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_take: got %b want 10", req_ready); end
        exp_q1.push_back(32'h0000_0888);
        tick();
        clr();
        set_req(0, 1'b0, 1'b0, 32'h30, 32'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL lock_block[%0d]: got %b want 00", i, req_ready); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lock_block_we[%0d]: got %b want 0", i, mem_we); end
            tick();
        end
        set_req(1, 1'b1, 1'b0, 32'h8, 32'h0000_0077, 4'hF);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL lock_release: got %b want 10", req_ready); end
        checks++; if (mem_wdata !== 32'h0000_0077) begin errors++; $display("FAIL lock_wdata: got %h want 77", mem_wdata); end
        exp_q1.push_back(32'h0000_0888);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lock_after: got %b want 01", req_ready); end
        exp_q0.push_back(32'hA0A0_A0A0);
        tick();
        clr();
        @(negedge clk);
        checks++; if (mem[8'h08] !== 32'h0000_0077) begin errors++; $display("FAIL lock_mem: got %h want 77", mem[8'h08]); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        clr();
        set_req(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rml_take: got %b want 01", req_ready); end
        exp_q0.push_back(32'hA0A0_A0A0);
        tick();
        clr();
        set_req(1, 1'b0, 1'b0, 32'h31, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rml_locked: got %b want 00", req_ready); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rml_in_reset: got %b want 00", req_ready); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rml_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rml_idle_grant: got %b want 10", req_ready); end
        exp_q1.push_back(32'hB1B1_B1B1);
        tick();
        clr();
        @(negedge clk);
        tick();
    endtask

    task automatic test_back_to_back();
        mem[8'h20] = 32'h0;
        clr();
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h5, 4'hF);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_wr_ready: got %b want 01", req_ready); end
        exp_q0.push_back(32'h0);
        tick();
        clr();
        set_req(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_rd_ready: got %b want 10", req_ready); end
        exp_q1.push_back(32'h5);
        tick();
        clr();
        @(negedge clk);
        tick();
    endtask

    task automatic test_addr_passthrough();
        clr();
        set_req(1, 1'b0, 1'b0, 32'hFFFF_0031, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (mem_addr !== 32'hFFFF_0031) begin errors++; $display("FAIL addr_pass: got %h want ffff0031", mem_addr); end
        exp_q1.push_back(32'hB1B1_B1B1);
        tick();
        clr();
        @(negedge clk);
        tick();
    endtask

    initial begin : main
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        clr();
        test_reset();
        test_single_read();
        test_strobed_write();
        test_tie();
        test_lock();
        test_reset_mid_lock();
        test_back_to_back();
        test_addr_passthrough();
        tick();
        checks++; if (exp_q0.size() != 0) begin errors++; $display("FAIL rsp0_missing: %0d pending want 0", exp_q0.size()); end
        checks++; if (exp_q1.size() != 0) begin errors++; $display("FAIL rsp1_missing: %0d pending want 0", exp_q1.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-ported data memory between two requesters: port 0 is the core load/store unit and port 1 is the DMA/program loader. Handles valid/ready request handshakes, merges byte-strobed writes into full 32-bit memory writes, and returns registered read responses one cycle after grant. Supports a lock that gives one port exclusive access for read-modify-write sequences. Sits between the requesters and the data memory's `MemWrite`/`addr`/`WriteData`/`ReadData` pins.

## Interface
- `ADDR_W`, default 16: address LSBs used by memory; upper bits are passed through but ignored.
- `DATA_W`, default 32: word width; strobe width is `DATA_W/8`.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `req_valid[i]` in 1, for i = 0..1: request present.
- `req_ready[i]` out 1: request accepted this cycle (grant).
- `req_we[i]` in 1: 1 = write, 0 = read.
- `req_lock[i]` in 1: hold exclusive ownership after this transfer.
- `req_addr[i]` in 32: word address.
- `req_wdata[i]` in DATA_W: write data.
- `req_wstrb[i]` in DATA_W/8: byte enables; only meaningful for writes.
- `rsp_valid[i]` out 1: response for the transfer granted last cycle.
- `rsp_rdata[i]` out DATA_W: read data, which is the pre-write word for writes.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out DATA_W: merged write word.
- `mem_rdata` in DATA_W: combinational memory read data.

## Operation
- **FSM states:**
  - `IDLE`: arbitrate.
  - `LOCK0`: port 0 owns memory exclusively.
  - `LOCK1`: port 1 owns memory exclusively.
- **Grant in `IDLE`:**
  - If only one port is valid, it wins.
  - If both are valid, the winner depends on the arbitration policy (see Configuration).
- **Grant in `LOCKn`:** only port n may be granted, and `req_ready` of the other port is held at 0.
- **State transitions:**
  - A granted transfer with `req_lock=1` moves the FSM to (or keeps it in) `LOCKn`.
  - A granted transfer by the owner with `req_lock=0` returns the FSM to `IDLE`.
  - In `LOCKn` with no owner request, the FSM stays in `LOCKn`.
- **Memory drive:**
  - `mem_addr` = granted `req_addr`; it is 0 when nothing is granted.
  - `mem_we` = `req_valid & req_ready & req_we` of the winner.
  - `mem_wdata` byte k = `req_wstrb[k] ? req_wdata byte k : mem_rdata byte k`, giving a read-merge-write in a single cycle.
  - A write with `wstrb=0` still asserts `mem_we` and rewrites the old word unchanged.
- **Response:** `rsp_valid[n]` is registered high for exactly one cycle after a grant to n, and `rsp_rdata[n]` is registered from `mem_rdata` in the grant cycle. `rsp_rdata` holds its value between responses.
- **Address arithmetic:** addresses are not modified. Wrap-around beyond `2**ADDR_W` words is the memory's responsibility.
- **Reset** (`reset=0` at the edge), including in the middle of a lock:
  - FSM → `IDLE`.
  - `rsp_valid` → 0 and `rsp_rdata` → 0.
  - Round-robin pointer → 1, so port 0 wins the first tie.
  - Any in-flight response is dropped.
  - While reset is asserted, `req_ready` = 0 and `mem_we` = 0.

## Timing
- Request accepted in cycle N when `req_valid & req_ready`. `req_ready` is combinational from `req_valid`, the state and the pointer; it never depends on `rsp_*`.
- Memory read and write both happen in cycle N. Response appears in cycle N+1, so latency is 1 and throughput is 1 transfer/cycle in total.
- Requesters must hold all `req_*` signals stable while `req_valid=1` and `req_ready=0`.
- A read from one port in the cycle after the other port wrote the same address returns the new data.
- Dropping `req_valid` without a grant is allowed and has no effect.

## Configuration
- **`DMEM_ARB_RR_EN` defined:** round-robin arbitration. A 1-bit `last` register records the last granted port and updates on every grant; on a tie, the port ≠ `last` wins.
- **`DMEM_ARB_RR_EN` undefined:** fixed priority, port 0 always wins a tie, and the `last` register is not built.
- Lock behaviour is identical in both builds.

## Structure
- **Shared package `dmem_pkg`:**
  - FSM state enum (`IDLE`, `LOCK0`, `LOCK1`).
  - `NUM_PORTS=2`.
  - Default `ADDR_W`/`DATA_W`.
  - Strobe width constant.
- **Sub-module `dmem_strb_merge`:** combinational byte merge of `old`, `new` and `strb`, parameterised by `DATA_W`. It is reusable by future cache fill logic.
- The arbiter FSM, pointer and response registers live in `dmem_arbiter`, which is instantiated above `DataMemory` in the top level.

## Test plan
- **Single read:** reset, preload mem[0x10]=0xDEADBEEF, then port 0 reads 0x10 → `req_ready[0]=1` in cycle N; `rsp_valid[0]=1` with `rsp_rdata[0]=0xDEADBEEF` in N+1.
- **Strobed write:** mem[0x4]=0x11223344, port 1 writes 0xAABBCCDD with strb=0b0101 → mem[0x4]=0x11BB33DD; `rsp_rdata[1]=0x11223344`.
- **Tie, RR build:** both ports valid for 4 cycles → grants alternate 0,1,0,1. **Tie, fixed build:** same stimulus → port 0 granted in all 4 cycles, with `req_ready[1]=0`.
- **Lock:** port 1 reads 0x8 with lock=1 while port 0 is continuously valid → port 0 is blocked until port 1 writes 0x8 with lock=0; port 0 is granted the next cycle.
- **Reset mid-lock:** in `LOCK0`, assert `reset=0` for 1 cycle → next cycle `rsp_valid=0`, FSM `IDLE`, and port 1 can be granted.
- **Back-to-back hazard:** port 0 writes 0x20=0x5 in cycle N, port 1 reads 0x20 in N+1 → `rsp_rdata[1]=0x5` in N+2.
